// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART receiver: 16x oversampled 8N1 deframer with rda/framing/overrun flags
module spart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic [15:0]          divisor,
    input  logic                 clr_rda,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] HALF_M1  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_M1  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t               state, state_d;
    logic                 rx_meta, rxs;
    logic [15:0]          cnt;
    logic                 tick;
    logic [SW-1:0]        scnt, scnt_d;
    logic [BW-1:0]        bcnt, bcnt_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 complete;

    // rxd is asynchronous; nothing downstream may look at it before the second flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    assign tick = (cnt == 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= 16'd0;
        else if (tick)
            cnt <= divisor;
        else
            cnt <= cnt - 16'd1;
    end

    always_comb begin
        state_d  = state;
        scnt_d   = scnt;
        bcnt_d   = bcnt;
        shreg_d  = shreg;
        complete = 1'b0;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        state_d = ST_START;
                        scnt_d  = '0;
                    end
                end
                ST_START: begin
                    if (scnt == HALF_M1) begin
                        if (!rxs) begin
                            state_d = ST_DATA;
                            scnt_d  = '0;
                            bcnt_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        scnt_d = scnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (scnt == FULL_M1) begin
                        shreg_d = {rxs, shreg[DATA_BITS-1:1]};
                        scnt_d  = '0;
                        bcnt_d  = bcnt + 1'b1;
                        if (bcnt == LAST_BIT)
                            state_d = ST_STOP;
                    end else begin
                        scnt_d = scnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop-bit lets an immediately following start bit be caught
                    if (scnt == FULL_M1) begin
                        complete = 1'b1;
                        scnt_d   = '0;
                        state_d  = rxs ? ST_IDLE : ST_BREAK;
                    end else begin
                        scnt_d = scnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rxs)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            scnt    <= '0;
            bcnt    <= '0;
            shreg   <= '0;
            rx_busy <= 1'b0;
        end else begin
            state   <= state_d;
            scnt    <= scnt_d;
            bcnt    <= bcnt_d;
            shreg   <= shreg_d;
            rx_busy <= (state_d != ST_IDLE);
        end
    end

    // A completion on the same edge as clr_rda takes priority over the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data     <= '0;
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else if (complete) begin
            rx_data     <= shreg;
            rda         <= 1'b1;
            framing_err <= ~rxs;
            overrun     <= rda & ~clr_rda;
        end else if (clr_rda) begin
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end
    end

endmodule
